// File: rtl/vga_timing_recovery.sv
// Recovers VGA line/frame geometry, pixel coordinates and lock status from a sampled sync/blank stream.
// Define VGA_TIMING_RECOVERY_STATS_EN to add the lock-loss and locked-frame counters.
module vga_timing_recovery #(
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           valid_i,
    input  logic           hsync_n_i,
    input  logic           vsync_n_i,
    input  logic           blank_n_i,
    output logic           valid_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           active_o,
    output logic           frame_o,
    output logic           locked_o,
    output logic           err_o,
    output logic [X_W-1:0] h_total_o,
    output logic [X_W-1:0] h_active_o,
    output logic [Y_W-1:0] v_total_o,
    output logic [Y_W-1:0] v_active_o
`ifdef VGA_TIMING_RECOVERY_STATS_EN
    ,
    output logic [15:0]    lock_loss_cnt_o,
    output logic [15:0]    frame_cnt_o
`endif
);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [X_W-1:0] X_ONE       = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE       = Y_W'(1);
    localparam logic [15:0]    LOCK_TARGET = 16'(LOCK_FRAMES);

    state_t         state;
    logic           hs_prev, vs_prev, bl_prev, vs_pend, line_act;
    logic [X_W-1:0] pcnt, hact_cnt, hact_last, x_cnt;
    logic [Y_W-1:0] lcnt, vact_cnt, y_cnt;
    logic [15:0]    match_cnt;

    logic           hs_fall, vs_fall, bl_fall, bl_rise, frame_mark;
    logic           pcnt_sat, checking, mismatch, lock_now;
    logic [X_W-1:0] line_len, hact_recent, x_next;
    logic [Y_W-1:0] frame_len, vact_frame, y_next;
    logic [15:0]    match_inc;

    // A blank line at the frame mark must not overwrite the active width, so keep the last non-empty line's count.
    always_comb begin
        hs_fall     = hs_prev & ~hsync_n_i;
        vs_fall     = vs_prev & ~vsync_n_i;
        bl_fall     = bl_prev & ~blank_n_i;
        bl_rise     = ~bl_prev & blank_n_i;
        frame_mark  = hs_fall & (vs_pend | vs_fall);
        pcnt_sat    = &pcnt;
        line_len    = pcnt + X_ONE;
        frame_len   = lcnt + Y_ONE;
        hact_recent = (hact_cnt != '0) ? hact_cnt : hact_last;
        vact_frame  = (line_act && !(&vact_cnt)) ? vact_cnt + Y_ONE : vact_cnt;
        match_inc   = match_cnt + 16'd1;
        checking    = (state == VERIFY) || (state == LOCKED);
        mismatch    = checking && (pcnt_sat
                                   || (hs_fall && (line_len != h_total_o))
                                   || (frame_mark && (frame_len != v_total_o)));
        lock_now    = !mismatch && ((state == LOCKED)
                                    || ((state == VERIFY) && frame_mark && (match_inc >= LOCK_TARGET)));
        x_next = x_cnt;
        if (bl_rise)
            x_next = '0;
        else if (blank_n_i)
            x_next = x_cnt + X_ONE;
        y_next = y_cnt;
        if (frame_mark)
            y_next = '0;
        else if (bl_fall)
            y_next = y_cnt + Y_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= SEARCH;
            hs_prev    <= 1'b1;
            vs_prev    <= 1'b1;
            bl_prev    <= 1'b1;
            vs_pend    <= 1'b0;
            line_act   <= 1'b0;
            pcnt       <= '0;
            hact_cnt   <= '0;
            hact_last  <= '0;
            x_cnt      <= '0;
            lcnt       <= '0;
            vact_cnt   <= '0;
            y_cnt      <= '0;
            match_cnt  <= '0;
            valid_o    <= 1'b0;
            x_o        <= '0;
            y_o        <= '0;
            active_o   <= 1'b0;
            frame_o    <= 1'b0;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
            h_total_o  <= '0;
            h_active_o <= '0;
            v_total_o  <= '0;
            v_active_o <= '0;
`ifdef VGA_TIMING_RECOVERY_STATS_EN
            lock_loss_cnt_o <= '0;
            frame_cnt_o     <= '0;
`endif
        end else begin
            valid_o <= valid_i;
            frame_o <= 1'b0;
            err_o   <= 1'b0;
            if (valid_i) begin
                hs_prev  <= hsync_n_i;
                vs_prev  <= vsync_n_i;
                bl_prev  <= blank_n_i;
                x_cnt    <= x_next;
                y_cnt    <= y_next;
                x_o      <= x_next;
                y_o      <= y_next;
                active_o <= blank_n_i & lock_now;
                locked_o <= lock_now;
                frame_o  <= frame_mark;
                vs_pend  <= (vs_pend | vs_fall) & ~frame_mark;

                if (hs_fall) begin
                    pcnt      <= '0;
                    hact_cnt  <= {{(X_W-1){1'b0}}, blank_n_i};
                    hact_last <= hact_recent;
                    line_act  <= blank_n_i;
                end else begin
                    if (!pcnt_sat)
                        pcnt <= pcnt + X_ONE;
                    if (blank_n_i && !(&hact_cnt))
                        hact_cnt <= hact_cnt + X_ONE;
                    line_act <= line_act | blank_n_i;
                end

                if (frame_mark) begin
                    lcnt     <= '0;
                    vact_cnt <= '0;
                end else if (hs_fall) begin
                    if (!(&lcnt))
                        lcnt <= lcnt + Y_ONE;
                    vact_cnt <= vact_frame;
                end

`ifdef VGA_TIMING_RECOVERY_STATS_EN
                if (frame_mark && locked_o && !(&frame_cnt_o))
                    frame_cnt_o <= frame_cnt_o + 16'd1;
`endif

                case (state)
                    SEARCH: begin
                        if (frame_mark)
                            state <= MEASURE;
                    end
                    MEASURE: begin
                        if (frame_mark) begin
                            h_total_o  <= line_len;
                            h_active_o <= hact_recent;
                            v_total_o  <= frame_len;
                            v_active_o <= vact_frame;
                            match_cnt  <= '0;
                            state      <= VERIFY;
                        end
                    end
                    VERIFY, LOCKED: begin
                        if (mismatch) begin
                            err_o <= 1'b1;
                            state <= SEARCH;
`ifdef VGA_TIMING_RECOVERY_STATS_EN
                            if ((state == LOCKED) && !(&lock_loss_cnt_o))
                                lock_loss_cnt_o <= lock_loss_cnt_o + 16'd1;
`endif
                        end else if (frame_mark && (state == VERIFY)) begin
                            match_cnt <= match_inc;
                            if (lock_now)
                                state <= LOCKED;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule
